// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package inst_fetch_pkg;

  localparam int          PC_W         = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INST     = 32'h0000_0000;

  typedef enum logic {
    S_BOOT = 1'b0,
    S_RUN  = 1'b1
  } if_state_e;

  // Sequential fetch step: next word, wrapping at 2^32.
  function automatic logic [PC_W-1:0] pc_incr(input logic [PC_W-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/inst_fetch_pc_gen.sv
// PC generator: holds the fetch PC and a deferred branch target, and
// resolves next-PC precedence (redirect > pending > pc+4 > hold).
module if_pc_gen
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            load,
  input  logic            if_valid,
  input  logic            jbr_valid,
  input  logic [PC_W-1:0] jbr_target,
  output logic [PC_W-1:0] pc
);

  logic            pending;
  logic [PC_W-1:0] tgt_q;

  // Next-PC selection. A redirect with a same-cycle load means the delay
  // slot is being captured right now, so the target can go straight to pc.
  // A redirect with the delay slot already held (if_valid, no load) also
  // goes straight to pc. Only when the slot is not yet captured and nothing
  // loads is the target parked until the next load.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc      <= RESET_PC;
      pending <= 1'b0;
      tgt_q   <= '0;
    end else if (jbr_valid && load) begin
      pc      <= jbr_target;
      pending <= 1'b0;
    end else if (jbr_valid && if_valid) begin
      pc <= jbr_target;
    end else if (jbr_valid) begin
      pending <= 1'b1;
      tgt_q   <= jbr_target;
    end else if (load) begin
      if (pending) begin
        pc      <= tgt_q;
        pending <= 1'b0;
      end else begin
        pc <= pc_incr(pc);
      end
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch front end: drives the combinational instruction ROM,
// captures the returned word into a one-entry output register and hands it
// to decode over if_valid/id_allowin. Branch redirects follow MIPS
// delay-slot semantics (the slot after a branch is always delivered).
// Optional build macro IF_PERF_CNT_EN adds fetch_cnt/stall_cnt counters.
//
//   state  | meaning
//   S_BOOT | one idle cycle after reset release, no fetch
//   S_RUN  | normal fetch; load when output empty or being consumed
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          ROM_AW   = 5
) (
  input  logic              clk,
  input  logic              resetn,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_inst,
  input  logic              id_allowin,
  output logic              if_valid,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_inst,
  input  logic              jbr_valid,
  input  logic [31:0]       jbr_target
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  if_state_e       state;
  logic [PC_W-1:0] pc;
  logic            load;

  assign rom_addr = pc[ROM_AW+1:2];
  assign load     = (state == S_RUN) && (!if_valid || id_allowin);

  if_pc_gen #(
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk        (clk),
    .resetn     (resetn),
    .load       (load),
    .if_valid   (if_valid),
    .jbr_valid  (jbr_valid),
    .jbr_target (jbr_target),
    .pc         (pc)
  );

  // FSM and output register; on a stall everything simply holds.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_BOOT;
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_inst  <= NOP_INST;
    end else begin
      case (state)
        S_BOOT: state <= S_RUN;
        S_RUN: begin
          if (load) begin
            if_valid <= 1'b1;
            if_pc    <= pc;
            if_inst  <= rom_inst;
          end
        end
        default: state <= S_BOOT;
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  // Transfer and stall counters, both free-running and wrapping.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (if_valid && id_allowin)  fetch_cnt <= fetch_cnt + 32'd1;
      if (if_valid && !id_allowin) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
